// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder/subtractor controller. Steps a single
//                1-bit full-adder slice over WIDTH-bit operands, LSB first,
//                one bit per clock, and presents a registered result with
//                carry-out and signed-overflow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  // Only the lower WIDTH-1 result bits need accumulating; the MSB comes
  // straight from the slice on the final edge.
  logic [WIDTH-2:0]   r_acc;

  logic               w_slice_sum;
  logic               w_slice_cout;
  logic [WIDTH-2:0]   w_acc_next;

  // The shared 1-bit full-adder slice, fed from the operand LSBs and the
  // carry held over from the previous bit.
  assign w_slice_sum  = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_slice_cout = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);

  // Right-shifting accumulator: each new sum bit enters at the top, so after
  // WIDTH-1 bits the first bit computed has reached position 0.
  generate
    if (WIDTH > 2) begin : g_acc_wide
      assign w_acc_next = {w_slice_sum, r_acc[WIDTH-2:1]};
    end else begin : g_acc_narrow
      assign w_acc_next = w_slice_sum;
    end
  endgenerate

  // Sequencer: load on start, one slice step per clock, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_acc   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_slice_cout;
          r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
          r_cnt   <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            // Overflow compares the carry into the MSB with the carry out of it.
            sum     <= {w_slice_sum, r_acc};
            cout    <= w_slice_cout;
            ovf     <= w_slice_cout ^ r_carry;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder/subtractor controller. It sequences one 1-bit full-adder slice (A, B, carry-in -> sum, carry-out) over WIDTH-bit operands, LSB first, one bit per clock. It latches operands on a start handshake and steps the slice through every bit while carrying between cycles. It then presents a registered result with carry and signed-overflow flags. It is the sequencing front end that lets the lab datapath reuse a single full-adder cell for multi-bit arithmetic.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk    input   1      system clock, rising-edge active
rst_n  input   1      asynchronous active-low reset
start  input   1      request a new operation; sampled only in IDLE
sub    input   1      0 = A+B, 1 = A-B; sampled with start
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
busy   output  1      high while an operation is in progress (RUN state)
done   output  1      one-cycle pulse when a new result is valid
sum    output  WIDTH  result; holds its value until the next completion
cout   output  1      carry out of MSB (for sub: 1 = no borrow)
ovf    output  1      two's-complement overflow of the last operation

Behaviour:
- Reset: one clock, asynchronous active-low reset. rst_n low forces FSM=IDLE and clears all registers: busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0, shift registers=0. Release is synchronous to clk.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1 at a rising edge.
  - RUN -> DONE at the edge that processes bit WIDTH-1.
  - DONE -> IDLE unconditionally after 1 cycle.
- Load (IDLE & start):
  - opA <= a.
  - opB <= sub ? ~b : b.
  - carry <= sub.
  - cnt <= 0.
  - acc <= 0.
- RUN, each edge:
  - Slice inputs are opA[0], opB[0], carry.
  - acc <= {slice_sum, acc[WIDTH-1:1]}.
  - carry <= slice_cout.
  - opA and opB shift right by 1.
  - cnt <= cnt+1.
  - Counter width is ceil(log2(WIDTH)).
- Last bit (cnt==WIDTH-1):
  - sum <= {slice_sum, acc[WIDTH-1:1]}.
  - cout <= slice_cout.
  - ovf <= slice_cout XOR carry, where carry is the carry into the MSB.
  - Next state is DONE.
- Outputs:
  - busy = (state==RUN), registered.
  - done = (state==DONE), high exactly 1 cycle.
  - sum/cout/ovf are stable from the done cycle until the next operation completes. They do not change at load or during RUN.
- Latency: start sampled at edge k. busy is high during cycles k+1..k+WIDTH. done and the new result are visible in cycle k+WIDTH+1. Maximum throughput is one op per WIDTH+2 cycles.
- start in RUN or DONE: ignored, with no queuing. a/b/sub may change freely after the load edge.
- start held continuously high: a new op is accepted at each IDLE visit, giving a period of WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH. For sub, cout=1 iff a>=b unsigned.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and sum/cout/ovf return to 0.

Test Plan:
1. WIDTH=8, start with a=0x5A, b=0x3C, sub=0 -> busy high 8 cycles; done in cycle 9 after start edge; sum=0x96, cout=0, ovf=1.
2. a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0. Then a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1, ovf=0.
3. a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1. Then a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0, ovf=0.
4. Start pulsed again at RUN cycle 3 with different operands -> ignored; result matches the first op; exactly one done pulse.
5. rst_n low for 1 cycle at RUN bit 4 -> busy=0, sum=0, cout=0, ovf=0 immediately (async); no done pulse. A following start with a=0x01, b=0x01 -> sum=0x02.
6. start tied high for 40 cycles with fixed operands -> done pulses every 10 cycles; sum stays constant between pulses; busy never high in the done cycle.
